zone_temporal_filter: RTL
=========================

// Module: zone_temporal_filter
// PURPOSE
//  Per-zone temporal IIR smoother and ambient-brightness scaler between block_360_ave and MiniLED_driver.
//  Consumes the serial zone stream (index/value per zone, frame-done pulse).
//  Smooths each zone against its previous-frame value to suppress backlight flicker.
//  Scales the result by the AP3216 ambient level; emits the same serial stream format.
// PARAMETERS
//  NUM_ZONES   360  zones per frame; index range 0..NUM_ZONES-1
//  IDX_W       9    zone index width
//  MIN_BRIGHT  16   floor on the effective brightness code (0..255)
// PORTS
//  i_pix_clk     in   1      sole clock (LVDS rx pixel clock)
//  rst_n         in   1      asynchronous active-low reset
//  i_zone_valid  in   1      zone sample strobe
//  i_zone_idx    in   IDX_W  zone index of sample
//  i_zone_data   in   8      zone gray value
//  i_frame_done  in   1      1-cycle pulse, end of zone frame
//  i_bright      in   8      ambient brightness code
//  i_alpha_shift in   2      smoothing shift k (0 = no smoothing)
//  o_zone_valid  out  1      output sample strobe
//  o_zone_idx    out  IDX_W  output zone index
//  o_zone_data   out  8      filtered, scaled value
//  o_frame_done  out  1      delayed frame-done pulse
//  o_frame_err   out  1      pulse with o_frame_done when zone count != NUM_ZONES
// BEHAVIOUR
//  - Reset: all outputs 0; history RAM contents don't-care; state S_PRIME; zone count 0; latched k=0, bright=255.
//  - Pipeline, fixed latency 3 cycles, no backpressure; accepts one sample per cycle.
//    S1: synchronous RAM read of prev[idx].
//    S2: compute the filtered value f; write f to prev[idx].
//    S3: scale f; register the outputs.
//  - Filter: diff = new - prev, 9b signed.
//    step = (diff + (diff>0 ? 2^k-1 : 0)) >>> k, i.e. ceil for rises, floor for falls.
//    f = prev + step; nonzero diff always moves by at least 1; f stays in 0..255.
//  - Forwarding: if the S2 write index equals the S1 read index in the same cycle, S1 takes the S2 write value.
//    Back-to-back samples to one index therefore see the latest value.
//  - FSM S_PRIME: f = new (history not yet valid).
//    S_PRIME -> S_RUN on i_frame_done with count == NUM_ZONES; otherwise remain in S_PRIME.
//    S_RUN stays in S_RUN; it returns to S_PRIME only on reset.
//  - Index >= NUM_ZONES: sample dropped, with no RAM write, no output and no count.
//  - Zone count increments on each valid in-range sample.
//    On i_frame_done, count is compared with NUM_ZONES, then cleared.
//    A valid sample in the same cycle as i_frame_done belongs to the ending frame.
//  - i_bright and i_alpha_shift are latched only on i_frame_done and apply from the next frame, so there is no mid-frame tearing.
//  - o_frame_done and o_frame_err are delayed 3 cycles, aligned to the last sample's output.
//  - Reset mid-frame: in-flight samples are discarded and outputs go to 0 immediately; the next frame is primed again.
// CONFIGURATION
//  ZTF_BRIGHT_SCALE_EN defined:
//    b = max(latched bright, MIN_BRIGHT); out = (f*(b+1)) >> 8; bright=255 gives out = f.
//  ZTF_BRIGHT_SCALE_EN undefined:
//    out = f; i_bright is ignored; latency is still 3 cycles (S3 is a plain register).
// TESTING
//  Reset: hold rst_n=0 for 5 cycles -> all outputs 0 with and without any input activity.
//  Prime frame, bright=255, k=2: zone 5 data 200 -> 3 cycles later o_zone_idx=5, data=200.
//    Full frame of 360 -> o_frame_done=1, o_frame_err=0.
//  Decay with k=2, zone 5 prev=200, new=0 over successive frames -> outputs 150, then 112, then 84.
//    Rise with k=3: prev 100, new 101 -> 101.
//  Hazard: zone 7 in two consecutive cycles, values 40 then 80, prev 0, k=1 in RUN -> outputs 20, then 50.
//  Scale (EN): f=200, bright=127 latched -> 100; bright=0 -> floor 16 gives 200*17>>8 = 13.
//  Errors: idx=400 -> no output; frame of 359 zones -> o_frame_err=1 and FSM stays S_PRIME.
//    Reset asserted mid-frame -> outputs 0 at once and the following frame is primed.

Source files
------------

// File: rtl/zone_temporal_filter.sv
// zone_temporal_filter
//   Per-zone temporal IIR smoother with optional ambient-brightness scaling.
//   Sits between the zone averager and the MiniLED driver. It takes the
//   serial zone stream (index/value per zone plus a frame-done pulse),
//   smooths each zone against its previous-frame value, and re-emits the
//   same stream format three cycles later.
//
//   Build option: define ZTF_BRIGHT_SCALE_EN to scale the filtered value by
//   the latched ambient brightness code. When it is undefined, i_bright is
//   ignored and the last stage is a plain register.
//
// Ports
//   i_pix_clk      sole clock
//   rst_n          asynchronous active-low reset
//   i_zone_valid   input sample strobe
//   i_zone_idx     input zone index
//   i_zone_data    input zone gray value
//   i_frame_done   one-cycle end-of-frame pulse
//   i_bright       ambient brightness code, latched on i_frame_done
//   i_alpha_shift  smoothing shift k, latched on i_frame_done
//   o_zone_valid   output sample strobe
//   o_zone_idx     output zone index
//   o_zone_data    filtered (and optionally scaled) value
//   o_frame_done   frame-done pulse aligned with the last sample's output
//   o_frame_err    pulses with o_frame_done when the zone count was wrong
//
// state   | meaning
// S_PRIME | history not trusted; filtered value = new sample
// S_RUN   | history valid; IIR smoothing active

module zone_temporal_filter #(
  parameter int NUM_ZONES  = 360,
  parameter int IDX_W      = 9,
  parameter int MIN_BRIGHT = 16
) (
  input  logic             i_pix_clk,
  input  logic             rst_n,
  input  logic             i_zone_valid,
  input  logic [IDX_W-1:0] i_zone_idx,
  input  logic [7:0]       i_zone_data,
  input  logic             i_frame_done,
  input  logic [7:0]       i_bright,
  input  logic [1:0]       i_alpha_shift,
  output logic             o_zone_valid,
  output logic [IDX_W-1:0] o_zone_idx,
  output logic [7:0]       o_zone_data,
  output logic             o_frame_done,
  output logic             o_frame_err
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {S_PRIME, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             in_range, frame_ok;
  logic [1:0]       k_q;
  logic [IDX_W-1:0] rd_idx;

  // S1 stage
  logic             s1_valid_q, s1_prime_q, s1_fd_q, s1_err_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [7:0]       s1_new_q, rd_q, fwd_data_q, prev_s1;
  logic [1:0]       s1_k_q;
  logic             fwd_q;

  // S2 stage
  logic signed [9:0] diff, bias, step, f_sum;
  logic [7:0]        f;
  logic              s2_valid_q, s2_fd_q, s2_err_q;
  logic [IDX_W-1:0]  s2_idx_q;
  logic [7:0]        s2_f_q, out_val;

  logic [7:0] prev_mem [NUM_ZONES];

  assign in_range = i_zone_valid && (32'(i_zone_idx) < NUM_ZONES);
  assign rd_idx   = in_range ? i_zone_idx : '0;

  // Saturating count so a runaway frame can never wrap back to NUM_ZONES.
  always_comb begin
    cnt_inc = cnt_q;
    if (in_range && (cnt_q != '1)) cnt_inc = cnt_q + 1'b1;
  end
  assign frame_ok = (cnt_inc == CNT_W'(NUM_ZONES));

  always_comb begin
    state_d = state_q;
    if (state_q == S_PRIME && i_frame_done && frame_ok) state_d = S_RUN;
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PRIME;
      cnt_q   <= '0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= i_frame_done ? '0 : cnt_inc;
      if (i_frame_done) k_q <= i_alpha_shift;
    end
  end

  // History RAM: registered read in S1, write of f in S2.
  always_ff @(posedge i_pix_clk) begin
    if (s1_valid_q) prev_mem[s1_idx_q] <= f;
    rd_q <= prev_mem[rd_idx];
  end

  // The RAM read this cycle cannot see the S2 write landing on the same
  // edge, so capture the write value and substitute it.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_new_q   <= '0;
      s1_prime_q <= 1'b0;
      s1_k_q     <= 2'd0;
      s1_fd_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      s1_valid_q <= in_range;
      s1_idx_q   <= i_zone_idx;
      s1_new_q   <= i_zone_data;
      s1_prime_q <= (state_q == S_PRIME);
      s1_k_q     <= k_q;
      s1_fd_q    <= i_frame_done;
      s1_err_q   <= i_frame_done && !frame_ok;
      fwd_q      <= s1_valid_q && (s1_idx_q == i_zone_idx);
      fwd_data_q <= f;
    end
  end

  assign prev_s1 = fwd_q ? fwd_data_q : rd_q;

  // Bias rises by 2^k-1 so rises round up and falls round down; any
  // nonzero difference therefore moves the value by at least one code.
  always_comb begin
    diff  = $signed({2'b00, s1_new_q}) - $signed({2'b00, prev_s1});
    bias  = '0;
    if (diff > 0) bias = $signed((10'd1 << s1_k_q) - 10'd1);
    step  = (diff + bias) >>> s1_k_q;
    f_sum = $signed({2'b00, prev_s1}) + step;
    f     = s1_prime_q ? s1_new_q : f_sum[7:0];
  end

`ifdef ZTF_BRIGHT_SCALE_EN
  logic [7:0]  bright_q, s1_bright_q, s2_bright_q, b_eff;
  logic [16:0] prod;

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q    <= 8'd255;
      s1_bright_q <= 8'd255;
      s2_bright_q <= 8'd255;
    end else begin
      if (i_frame_done) bright_q <= i_bright;
      s1_bright_q <= bright_q;
      s2_bright_q <= s1_bright_q;
    end
  end

  always_comb begin
    b_eff   = (32'(s2_bright_q) < MIN_BRIGHT) ? 8'(MIN_BRIGHT) : s2_bright_q;
    prod    = 17'(s2_f_q) * (17'(b_eff) + 17'd1);
    out_val = prod[15:8];
  end
`else
  logic bright_unused;
  assign bright_unused = ^i_bright;
  assign out_val = s2_f_q;
`endif

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_idx_q     <= '0;
      s2_f_q       <= '0;
      s2_fd_q      <= 1'b0;
      s2_err_q     <= 1'b0;
      o_zone_valid <= 1'b0;
      o_zone_idx   <= '0;
      o_zone_data  <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      s2_valid_q   <= s1_valid_q;
      s2_idx_q     <= s1_idx_q;
      s2_f_q       <= f;
      s2_fd_q      <= s1_fd_q;
      s2_err_q     <= s1_err_q;
      o_zone_valid <= s2_valid_q;
      o_zone_idx   <= s2_idx_q;
      o_zone_data  <= out_val;
      o_frame_done <= s2_fd_q;
      o_frame_err  <= s2_err_q;
    end
  end

endmodule
